pipe_if_stage: RTL

PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/mux4x32.sv | 23 ++
 rtl/pipe_if_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the instruction-fetch stage.
package pipe_pkg;

    localparam logic [1:0] PCS_SEQ    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JR     = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } if_state_t;

    // Sequential successor; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/mux4x32.sv
// 4:1 word mux keyed by the ID next-PC select encoding.
module mux4x32
    import pipe_pkg::*;
(
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [1:0]  s,
    output logic [31:0] y
);

    always_comb begin
        y = a0;
        case (s)
            PCS_BRANCH: y = a1;
            PCS_JR:     y = a2;
            PCS_JUMP:   y = a3;
            default:    y = a0;
        endcase
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC, IF/ID register, fetch/hold FSM and
// delayed-branch redirect capture for a variable-latency instruction memory.
module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] da,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid
);

    if_state_t   state;
    if_state_t   state_nxt;
    logic [31:0] ibuf;
    logic [31:0] redir_pc;
    logic        redir_v;
    logic [31:0] pc4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic [31:0] fetched;
    logic [1:0]  target_sel;
    logic        redir_req;
    logic        advance;
    logic        park;
    logic        bubble;

    assign pc4       = pc_plus4(pc);
    assign imem_addr = pc;

    // ID redirect only counts when ID actually holds a real instruction and consumes it.
    assign redir_req  = dvalid && !wpcir && (pcsource != PCS_SEQ);
    assign target_sel = redir_req ? pcsource : PCS_SEQ;

    mux4x32 u_target_mux (
        .a0 (pc4),
        .a1 (bpc),
        .a2 (da),
        .a3 (jpc),
        .s  (target_sel),
        .y  (target)
    );

    // A pending redirect belongs to an older branch, so it outranks a new one.
    assign next_pc = redir_v ? redir_pc : target;
    assign fetched = (state == ST_HOLD) ? ibuf : imem_rdata;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        advance   = 1'b0;
        park      = 1'b0;
        bubble    = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready && !wpcir) begin
                    advance = 1'b1;
                end else if (imem_ready) begin
                    park      = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (!wpcir) begin
                    bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!wpcir) begin
                    advance   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc       <= RESET_PC;
            dpc4     <= 32'h0;
            inst     <= NOP_INST;
            dvalid   <= 1'b0;
            ibuf     <= 32'h0;
            redir_pc <= 32'h0;
            redir_v  <= 1'b0;
        end else begin
            if (advance) begin
                pc     <= next_pc;
                dpc4   <= pc4;
                inst   <= fetched;
                dvalid <= 1'b1;
            end else if (bubble) begin
                inst   <= NOP_INST;
                dvalid <= 1'b0;
            end

            if (park) begin
                ibuf <= imem_rdata;
            end

            // Delay slot still outstanding: remember where to go once it lands.
            if (advance) begin
                redir_v <= 1'b0;
            end else if (redir_req && !redir_v) begin
                redir_v  <= 1'b1;
                redir_pc <= target;
            end
        end
    end

endmodule
